// File: rtl/sirena_driver.sv
// Horn driver: edge-triggered entry delay, pulsed alarm with auto-timeout,
// latched panic mode and a silence/disarm input. All outputs are registered.
module sirena_driver #(
   parameter int TICK_DIV    = 50000,
   parameter int ENTRY_TICKS = 15000,
   parameter int ON_TICKS    = 500,
   parameter int OFF_TICKS   = 500,
   parameter int MAX_CYCLES  = 120
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trig_in,
   input  logic       panic_in,
   input  logic       silence,
   output logic       horn,
   output logic       alarm_active,
   output logic [1:0] state_o,
   output logic       timeout_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      PREALARM = 2'b01,
      ALARM    = 2'b10,
      PANIC    = 2'b11
   } state_t;

   typedef enum logic {
      PH_ON  = 1'b0,
      PH_OFF = 1'b1
   } phase_t;

   localparam int TICK_MAX = (ENTRY_TICKS > ON_TICKS)
                           ? ((ENTRY_TICKS > OFF_TICKS) ? ENTRY_TICKS : OFF_TICKS)
                           : ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
   localparam int PW = $clog2(TICK_DIV - 1) + 1;
   localparam int TW = $clog2(TICK_MAX) + 1;
   localparam int CW = $clog2(MAX_CYCLES) + 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_TICKS - 1);
   localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
   localparam logic [CW-1:0] CYC_LAST   = CW'(MAX_CYCLES - 1);

   state_t        state, next_state;
   phase_t        phase, next_phase, phase_d;
   logic [PW-1:0] presc;
   logic [TW-1:0] tick_cnt;
   logic [TW-1:0] tick_last;
   logic [CW-1:0] cyc_cnt;
   logic          trig_q;
   logic          trig_evt;
   logic          timing;
   logic          tick;
   logic          expire;
   logic          restart;
   logic          cyc_inc;
   logic          timeout_nxt;
   logic          horn_nxt;

   assign trig_evt = trig_in & ~trig_q;
   assign timing   = (state == PREALARM) || (state == ALARM);
   assign tick     = (presc == PRESC_LAST);
   assign expire   = tick && (tick_cnt == tick_last);
   assign state_o  = state;

   // NOTE: every variable driven here gets a default first so no path infers a latch.
   always_comb begin
      next_state  = state;
      next_phase  = phase;
      cyc_inc     = 1'b0;
      timeout_nxt = 1'b0;
      tick_last   = '0;

      unique case (state)
         IDLE: begin
            if (panic_in)                  next_state = PANIC;
            else if (!silence && trig_evt) next_state = PREALARM;
         end
         PREALARM: begin
            tick_last = ENTRY_LAST;
            if (panic_in)     next_state = PANIC;
            else if (silence) next_state = IDLE;
            else if (expire)  next_state = ALARM;
         end
         ALARM: begin
            tick_last = (phase == PH_ON) ? ON_LAST : OFF_LAST;
            if (panic_in)     next_state = PANIC;
            else if (silence) next_state = IDLE;
            else if (expire) begin
               if (phase == PH_ON) begin
                  next_phase = PH_OFF;
               end else if (cyc_cnt == CYC_LAST) begin
                  next_state  = IDLE;
                  timeout_nxt = 1'b1;
               end else begin
                  cyc_inc    = 1'b1;
                  next_phase = PH_ON;
               end
            end
         end
         PANIC: begin
            if (silence && !panic_in) next_state = IDLE;
         end
      endcase

      // Any state change lands in the ON phase so ALARM always opens sounding.
      phase_d  = (next_state != state) ? PH_ON : next_phase;
      restart  = (next_state != state) || (phase_d != phase);
      horn_nxt = (next_state == PANIC) || ((next_state == ALARM) && (phase_d == PH_ON));
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         phase        <= PH_ON;
         presc        <= '0;
         tick_cnt     <= '0;
         cyc_cnt      <= '0;
         trig_q       <= 1'b0;
         horn         <= 1'b0;
         alarm_active <= 1'b0;
         timeout_o    <= 1'b0;
      end else begin
         state  <= next_state;
         phase  <= phase_d;
         trig_q <= trig_in;

         if (restart || !timing) begin
            presc    <= '0;
            tick_cnt <= '0;
         end else if (tick) begin
            presc    <= '0;
            tick_cnt <= tick_cnt + TW'(1);
         end else begin
            presc <= presc + PW'(1);
         end

         if ((state != ALARM) || (next_state != ALARM)) cyc_cnt <= '0;
         else if (cyc_inc)                              cyc_cnt <= cyc_cnt + CW'(1);

         horn         <= horn_nxt;
         alarm_active <= (next_state != IDLE);
         timeout_o    <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_sirena_driver.sv
// Self-checking bench for sirena_driver: directed scenarios with fixed
// expectations plus a randomized run compared against a cycle-count model.
module tb_sirena_driver;

   localparam int TICK_DIV    = 2;
   localparam int ENTRY_TICKS = 3;
   localparam int ON_TICKS    = 2;
   localparam int OFF_TICKS   = 1;
   localparam int MAX_CYCLES  = 2;

   localparam int S_IDLE  = 0;
   localparam int S_PRE   = 1;
   localparam int S_ALARM = 2;
   localparam int S_PANIC = 3;

   logic       clk;
   logic       rst_n;
   logic       trig_in;
   logic       panic_in;
   logic       silence;
   logic       horn;
   logic       alarm_active;
   logic [1:0] state_o;
   logic       timeout_o;

   int checks   = 0;
   int failures = 0;

   // Reference model: state plus cycles spent in the current timed segment.
   int m_state;
   bit m_on;
   int m_elapsed;
   int m_periods;
   bit m_trig_q;
   bit m_horn;
   bit m_active;
   bit m_timeout;

   sirena_driver #(
      .TICK_DIV    (TICK_DIV),
      .ENTRY_TICKS (ENTRY_TICKS),
      .ON_TICKS    (ON_TICKS),
      .OFF_TICKS   (OFF_TICKS),
      .MAX_CYCLES  (MAX_CYCLES)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .trig_in      (trig_in),
      .panic_in     (panic_in),
      .silence      (silence),
      .horn         (horn),
      .alarm_active (alarm_active),
      .state_o      (state_o),
      .timeout_o    (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state   = S_IDLE;
      m_on      = 1'b1;
      m_elapsed = 0;
      m_periods = 0;
      m_trig_q  = 1'b0;
      m_horn    = 1'b0;
      m_active  = 1'b0;
      m_timeout = 1'b0;
   endtask

   task automatic model_step(input bit t, input bit p, input bit s);
      bit evt;
      bit done;
      bit non;
      int ns;
      int seg;
      evt = t && !m_trig_q;
      ns  = m_state;
      non = m_on;
      m_timeout = 1'b0;
      if (m_state == S_PRE) seg = ENTRY_TICKS * TICK_DIV;
      else                  seg = (m_on ? ON_TICKS : OFF_TICKS) * TICK_DIV;
      done = (m_elapsed == seg - 1);
      case (m_state)
         S_IDLE: begin
            if (p)               ns = S_PANIC;
            else if (!s && evt)  ns = S_PRE;
         end
         S_PRE: begin
            if (p)         ns = S_PANIC;
            else if (s)    ns = S_IDLE;
            else if (done) ns = S_ALARM;
         end
         S_ALARM: begin
            if (p)      ns = S_PANIC;
            else if (s) ns = S_IDLE;
            else if (done) begin
               if (m_on) non = 1'b0;
               else if (m_periods + 1 == MAX_CYCLES) begin
                  ns = S_IDLE;
                  m_timeout = 1'b1;
               end else begin
                  m_periods++;
                  non = 1'b1;
               end
            end
         end
         default: begin
            if (s && !p) ns = S_IDLE;
         end
      endcase
      if (ns != m_state) begin
         non       = 1'b1;
         m_elapsed = 0;
         m_periods = 0;
      end else if (non != m_on) begin
         m_elapsed = 0;
      end else begin
         m_elapsed++;
      end
      m_state  = ns;
      m_on     = non;
      m_trig_q = t;
      m_horn   = (ns == S_PANIC) || (ns == S_ALARM && non);
      m_active = (ns != S_IDLE);
   endtask

   task automatic cycle(input bit t, input bit p, input bit s);
      trig_in  = t;
      panic_in = p;
      silence  = s;
      @(posedge clk);
      model_step(t, p, s);
      #1;
      check("model_state",   state_o,      m_state);
      check("model_horn",    horn,         m_horn);
      check("model_active",  alarm_active, m_active);
      check("model_timeout", timeout_o,    m_timeout);
   endtask

   initial begin
      bit rt;
      bit rp;
      bit rs;
      bit exp_horn;
      int exp_state;
      rst_n    = 1'b0;
      trig_in  = 1'b0;
      panic_in = 1'b0;
      silence  = 1'b0;
      model_reset();

      // Reset held across several clocks.
      repeat (5) begin
         @(posedge clk);
         #1;
         check("rst_horn",    horn,         1'b0);
         check("rst_active",  alarm_active, 1'b0);
         check("rst_state",   state_o,      2'b00);
         check("rst_timeout", timeout_o,    1'b0);
      end
      #3 rst_n = 1'b1;
      cycle(0, 0, 0);

      // Full alarm: 6 entry cycles, 1x4 0x2 1x4 0x2, timeout, no retrigger.
      for (int i = 0; i < 23; i++) begin
         cycle(1, 0, 0);
         exp_state = (i < 6) ? 1 : (i < 18) ? 2 : 0;
         exp_horn  = ((i >= 6) && (i < 10)) || ((i >= 12) && (i < 16));
         check("full_state",   state_o,   exp_state);
         check("full_horn",    horn,      exp_horn);
         check("full_timeout", timeout_o, (i == 18));
      end
      cycle(0, 0, 0);

      // Abort during entry delay.
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("abort_pre", state_o, 2'b01);
      cycle(1, 0, 1);
      check("abort_state", state_o, 2'b00);
      check("abort_horn",  horn,    1'b0);
      for (int i = 0; i < 12; i++) begin
         cycle(1, 0, 0);
         check("abort_quiet_horn", horn,      1'b0);
         check("abort_quiet_to",   timeout_o, 1'b0);
      end
      cycle(0, 0, 0);

      // Panic entry, silence while panic held, release.
      cycle(0, 1, 0);
      check("panic_state", state_o, 2'b11);
      check("panic_horn",  horn,    1'b1);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 1);
         check("panic_hold_horn", horn, 1'b1);
      end
      cycle(0, 0, 1);
      check("panic_exit_state", state_o, 2'b00);
      check("panic_exit_horn",  horn,    1'b0);

      // Panic preempts ALARM in an OFF phase.
      for (int i = 0; i < 11; i++) cycle(1, 0, 0);
      check("pre_off_state", state_o, 2'b10);
      check("pre_off_horn",  horn,    1'b0);
      cycle(1, 1, 0);
      check("preempt_state", state_o, 2'b11);
      check("preempt_horn",  horn,    1'b1);
      for (int i = 0; i < 20; i++) begin
         cycle(1, 1, 0);
         check("preempt_hold_horn", horn,      1'b1);
         check("preempt_hold_to",   timeout_o, 1'b0);
      end
      cycle(1, 0, 1);
      check("preempt_exit", state_o, 2'b00);
      cycle(0, 0, 0);

      // Async reset mid-ALARM, then a fresh full entry delay.
      for (int i = 0; i < 7; i++) cycle(1, 0, 0);
      check("async_pre_horn", horn, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_horn",  horn,    1'b0);
      check("async_state", state_o, 2'b00);
      check("async_active", alarm_active, 1'b0);
      model_reset();
      trig_in = 1'b0;
      @(posedge clk);
      #1;
      check("async_held_state", state_o, 2'b00);
      #3 rst_n = 1'b1;
      cycle(0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         cycle(1, 0, 0);
         check("restart_state", state_o, (i < 6) ? 1 : 2);
         check("restart_horn",  horn,    (i == 6));
      end
      cycle(0, 0, 1);

      // Randomized run against the model.
      rt = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0) rt = ~rt;
         rp = ($urandom_range(39) == 0);
         rs = ($urandom_range(24) == 0);
         cycle(rt, rp, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
